// File: rtl/adjust_step_control.sv
// Held-button to step-pulse controller: one pulse on press, auto-repeat after a hold delay.
// Optional repeat acceleration is enabled by defining ADJUST_ACCEL_EN.
module adjust_step_control #(
  parameter int FIELDS              = 3,
  parameter int HOLD_CYCLES         = 500,
  parameter int REPEAT_CYCLES       = 100,
  parameter int ACCEL_AFTER         = 8,
  parameter int ACCEL_REPEAT_CYCLES = 25,
  parameter int CNT_W               = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adjust_increment,
  input  logic              adjust_decrement,
  input  logic [FIELDS-1:0] adjust_mode,
  output logic [FIELDS-1:0] step_inc,
  output logic [FIELDS-1:0] step_dec,
  output logic              busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} state_t;

  localparam logic [CNT_W-1:0] LP_HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_REPEAT_LOAD = CNT_W'(REPEAT_CYCLES - 1);

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic              r_prev_req;
  logic [FIELDS:0]   r_prev_key;
  logic [FIELDS-1:0] r_step_inc, r_step_dec;

  logic              w_inc, w_dec, w_mode_valid, w_req, w_trigger, w_pulse;
  logic [FIELDS:0]   w_key;
  logic [CNT_W-1:0]  w_repeat_load;

  assign w_inc        = adjust_increment & ~adjust_decrement;
  assign w_dec        = adjust_decrement & ~adjust_increment;
  assign w_mode_valid = $onehot(adjust_mode);
  assign w_req        = (w_inc | w_dec) & w_mode_valid;
  assign w_key        = {w_dec, adjust_mode};
  // A key change while still requesting restarts the hold just like a fresh press.
  assign w_trigger    = w_req & (~r_prev_req | (w_key != r_prev_key));

`ifdef ADJUST_ACCEL_EN
  localparam int RC_W = (ACCEL_AFTER > 0) ? $clog2(ACCEL_AFTER + 1) : 1;
  localparam logic [RC_W-1:0]  LP_RC_MAX     = RC_W'(ACCEL_AFTER);
  localparam logic [CNT_W-1:0] LP_ACCEL_LOAD = CNT_W'(ACCEL_REPEAT_CYCLES - 1);

  logic [RC_W-1:0] r_rcnt, w_rcnt_next, w_rcnt_sat;

  assign w_rcnt_sat    = (r_rcnt == LP_RC_MAX) ? r_rcnt : r_rcnt + RC_W'(1);
  // The reload chosen at a repeat pulse already counts that pulse.
  assign w_repeat_load = (w_rcnt_sat >= LP_RC_MAX) ? LP_ACCEL_LOAD : LP_REPEAT_LOAD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rcnt <= '0;
    end else begin
      r_rcnt <= w_rcnt_next;
    end
  end
`else
  logic w_unused_accel;
  assign w_unused_accel = (ACCEL_AFTER + ACCEL_REPEAT_CYCLES) != 0;
  assign w_repeat_load  = LP_REPEAT_LOAD;
`endif

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pulse      = 1'b0;
`ifdef ADJUST_ACCEL_EN
    w_rcnt_next  = r_rcnt;
`endif
    if (!w_req) begin
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
`ifdef ADJUST_ACCEL_EN
      w_rcnt_next  = '0;
`endif
    end else if (w_trigger) begin
      w_pulse      = 1'b1;
      w_cnt_next   = LP_HOLD_LOAD;
      w_state_next = ST_HOLD;
`ifdef ADJUST_ACCEL_EN
      w_rcnt_next  = '0;
`endif
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_cnt == '0) begin
            w_pulse      = 1'b1;
            w_cnt_next   = LP_REPEAT_LOAD;
            w_state_next = ST_REPEAT;
          end else begin
            w_cnt_next = r_cnt - CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (r_cnt == '0) begin
            w_pulse    = 1'b1;
            w_cnt_next = w_repeat_load;
`ifdef ADJUST_ACCEL_EN
            w_rcnt_next = w_rcnt_sat;
`endif
          end else begin
            w_cnt_next = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_prev_req <= 1'b0;
      r_prev_key <= '0;
      r_step_inc <= '0;
      r_step_dec <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_prev_req <= w_req;
      r_prev_key <= w_key;
      r_step_inc <= (w_pulse & w_inc) ? adjust_mode : '0;
      r_step_dec <= (w_pulse & w_dec) ? adjust_mode : '0;
    end
  end

  assign step_inc = r_step_inc;
  assign step_dec = r_step_dec;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_adjust_step_control.sv
// Self-checking bench for adjust_step_control: directed schedule checks plus
// randomized button/mode stimulus against a time-schedule reference model.
module tb_adjust_step_control;

  localparam int FIELDS = 3;
  localparam int HOLD   = 4;
  localparam int REP    = 3;
  localparam int AA     = 2;
  localparam int AR     = 2;
`ifdef ADJUST_ACCEL_EN
  localparam bit ACCEL  = 1'b1;
`else
  localparam bit ACCEL  = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              adj_inc = 1'b0;
  logic              adj_dec = 1'b0;
  logic [FIELDS-1:0] adj_mode = '0;
  logic [FIELDS-1:0] step_inc, step_dec;
  logic              busy;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state: schedule expressed as edges elapsed since the trigger
  bit                m_prev_req = 0;
  logic [FIELDS:0]   m_prev_key = '0;
  bit                m_active = 0;
  bit                m_in_repeat = 0;
  int                m_elapsed = 0;
  int                m_next_due = 0;
  int                m_nrep = 0;
  logic [FIELDS-1:0] m_inc = '0;
  logic [FIELDS-1:0] m_dec = '0;
  bit                m_busy = 0;

  adjust_step_control #(
    .FIELDS(FIELDS), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP),
    .ACCEL_AFTER(AA), .ACCEL_REPEAT_CYCLES(AR), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .adjust_increment(adj_inc), .adjust_decrement(adj_dec),
    .adjust_mode(adj_mode),
    .step_inc(step_inc), .step_dec(step_dec), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_update();
    bit i, d, req, trig, pulse;
    logic [FIELDS:0] key;
    if (rst) begin
      m_prev_req = 0; m_prev_key = '0; m_active = 0;
      m_inc = '0; m_dec = '0; m_busy = 0;
      return;
    end
    i     = adj_inc && !adj_dec;
    d     = adj_dec && !adj_inc;
    req   = (i || d) && ($countones(adj_mode) == 1);
    key   = {d, adj_mode};
    trig  = req && (!m_prev_req || key != m_prev_key);
    pulse = 0;
    if (!req) begin
      m_active = 0;
    end else if (trig) begin
      m_active = 1; m_in_repeat = 0; m_elapsed = 0;
      m_next_due = HOLD; m_nrep = 0; pulse = 1;
    end else if (m_active) begin
      m_elapsed++;
      if (m_elapsed == m_next_due) begin
        pulse = 1;
        if (!m_in_repeat) begin
          m_in_repeat = 1;
          m_next_due += REP;
        end else begin
          m_nrep++;
          m_next_due += (ACCEL && m_nrep >= AA) ? AR : REP;
        end
      end
    end
    m_inc = (pulse && i) ? adj_mode : '0;
    m_dec = (pulse && d) ? adj_mode : '0;
    m_busy = m_active;
    m_prev_req = req;
    m_prev_key = key;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic go_idle();
    adj_inc = 0; adj_dec = 0; adj_mode = '0;
    tick(); tick();
  endtask

  task automatic test_reset();
    logic [FIELDS-1:0] exp_inc;
    rst = 1; adj_inc = 1; adj_dec = 0; adj_mode = 3'b010;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++;
      if ({busy, step_inc, step_dec} !== 7'b0) $display("FAIL reset_hold k=%0d busy/inc/dec=%b required 0", k, {busy, step_inc, step_dec});
      else n_pass++;
    end
    rst = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      exp_inc = (k == 0 || k == 4 || k == 7 || k == 10) ? 3'b010 : 3'b000;
      n_total++;
      if (step_inc !== exp_inc || step_dec !== 3'b000 || busy !== 1'b1)
        $display("FAIL reset_autorepeat E+%0d inc=%b dec=%b busy=%b required inc=%b dec=000 busy=1", k, step_inc, step_dec, busy, exp_inc);
      else n_pass++;
    end
  endtask

  task automatic test_release();
    logic [FIELDS-1:0] exp_inc;
    go_idle();
    adj_mode = 3'b001; adj_inc = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_inc = (k == 0 || k == 4) ? 3'b001 : 3'b000;
      n_total++;
      if (step_inc !== exp_inc || busy !== (k < 6))
        $display("FAIL release E+%0d inc=%b busy=%b required inc=%b busy=%b", k, step_inc, busy, exp_inc, (k < 6));
      else n_pass++;
      if (k == 5) adj_inc = 0;
    end
  endtask

  task automatic test_mode_switch();
    logic [FIELDS-1:0] exp_inc;
    go_idle();
    adj_mode = 3'b010; adj_inc = 1;
    for (int k = 0; k < 9; k++) begin
      tick();
      exp_inc = (k == 0) ? 3'b010 : ((k == 2 || k == 6) ? 3'b001 : 3'b000);
      n_total++;
      if (step_inc !== exp_inc || step_dec !== 3'b000)
        $display("FAIL mode_switch E+%0d inc=%b dec=%b required inc=%b dec=000", k, step_inc, step_dec, exp_inc);
      else n_pass++;
      if (k == 1) adj_mode = 3'b001;
    end
  endtask

  task automatic test_invalid();
    go_idle();
    adj_inc = 1; adj_dec = 1; adj_mode = 3'b100;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_total++;
      if ({busy, step_inc, step_dec} !== 7'b0) $display("FAIL invalid_both k=%0d busy/inc/dec=%b required 0", k, {busy, step_inc, step_dec});
      else n_pass++;
    end
    adj_dec = 0; adj_mode = 3'b011;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_total++;
      if ({step_inc, step_dec} !== 6'b0) $display("FAIL invalid_multihot k=%0d inc/dec=%b required 0", k, {step_inc, step_dec});
      else n_pass++;
    end
    adj_mode = 3'b100;
    tick();
    n_total++;
    if (step_inc !== 3'b100 || busy !== 1'b1) $display("FAIL invalid_recover inc=%b busy=%b required inc=100 busy=1", step_inc, busy);
    else n_pass++;
  endtask

  task automatic test_decrement();
    logic [FIELDS-1:0] exp_inc, exp_dec;
    go_idle();
    adj_dec = 1; adj_mode = 3'b100;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_dec = (k == 0) ? 3'b100 : 3'b000;
      exp_inc = (k == 2 || k == 6) ? 3'b100 : 3'b000;
      n_total++;
      if (step_inc !== exp_inc || step_dec !== exp_dec)
        $display("FAIL decrement E+%0d inc=%b dec=%b required inc=%b dec=%b", k, step_inc, step_dec, exp_inc, exp_dec);
      else n_pass++;
      if (k == 1) begin adj_dec = 0; adj_inc = 1; end
    end
  endtask

  task automatic test_accel();
    logic [FIELDS-1:0] exp_inc;
    bit due;
    go_idle();
    adj_inc = 1; adj_mode = 3'b001;
    for (int k = 0; k < 18; k++) begin
      tick();
      if (ACCEL) due = (k == 0 || k == 4 || k == 7 || k == 10 || k == 12 || k == 14);
      else       due = (k == 0 || k == 4 || k == 7 || k == 10 || k == 13 || k == 16);
      exp_inc = due ? 3'b001 : 3'b000;
      n_total++;
      if (step_inc !== exp_inc) $display("FAIL accel E+%0d inc=%b required %b", k, step_inc, exp_inc);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    go_idle();
    adj_inc = 1; adj_mode = 3'b100;
    tick();
    n_total++;
    if (step_inc !== 3'b100) $display("FAIL async_pre inc=%b required 100", step_inc);
    else n_pass++;
    #2 rst = 1;
    #1;
    n_total++;
    if ({busy, step_inc, step_dec} !== 7'b0) $display("FAIL async_reset busy/inc/dec=%b required 0", {busy, step_inc, step_dec});
    else n_pass++;
    tick();
    rst = 0;
    tick();
    n_total++;
    if (step_inc !== 3'b100 || busy !== 1'b1) $display("FAIL async_retrigger inc=%b busy=%b required inc=100 busy=1", step_inc, busy);
    else n_pass++;
  endtask

  task automatic test_random();
    int hold;
    go_idle();
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 3))
        0: begin adj_inc = 1; adj_dec = 0; end
        1: begin adj_inc = 0; adj_dec = 1; end
        2: begin adj_inc = 1; adj_dec = 1; end
        default: begin adj_inc = 0; adj_dec = 0; end
      endcase
      if ($urandom_range(0, 9) < 7) adj_mode = 3'b001 << $urandom_range(0, 2);
      else adj_mode = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 16);
      for (int c = 0; c < hold; c++) begin
        tick();
        n_total++;
        if (step_inc !== m_inc || step_dec !== m_dec || busy !== m_busy || $countones({step_inc, step_dec}) > 1)
          $display("FAIL random n=%0d c=%0d inc=%b dec=%b busy=%b required inc=%b dec=%b busy=%b", n, c, step_inc, step_dec, busy, m_inc, m_dec, m_busy);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_mode_switch();
    test_invalid();
    test_decrement();
    test_accel();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/adjust_step_control.md
# adjust_step_control

Parametrised successor to the clock's adjust increment controller. Turns held adjust buttons into single-cycle step pulses for one of FIELDS time fields, chosen by a one-hot mode bus. Supports increment and decrement, a hold delay before auto-repeat, and a fixed repeat rate. Sits between the synchronised/debounced button inputs and the per-field counters of the time-keeping datapath.

## Interface
- FIELDS, 3: number of adjustable fields; bit 0 = seconds, 1 = minutes, 2 = hours in the default build.
- HOLD_CYCLES, 500: clk cycles from the first pulse to the first auto-repeat pulse; must be ≥ 2.
- REPEAT_CYCLES, 100: clk cycles between auto-repeat pulses; must be ≥ 2.
- ACCEL_AFTER, 8: repeat pulses before acceleration (used only with ADJUST_ACCEL_EN).
- ACCEL_REPEAT_CYCLES, 25: accelerated repeat period; must be ≥ 2 (used only with ADJUST_ACCEL_EN).
- CNT_W, 16: width of the internal interval counter; must hold the largest cycle parameter.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- adjust_increment  input  1  increment button level, already synchronous to clk.
- adjust_decrement  input  1  decrement button level, already synchronous to clk.
- adjust_mode  input  FIELDS  one-hot field select; zero means not adjusting.
- step_inc  output  FIELDS  one-cycle increment pulse for the selected field.
- step_dec  output  FIELDS  one-cycle decrement pulse for the selected field.
- busy  output  1  high while the FSM is in HOLD or REPEAT.

## Operation
- Direction: inc = adjust_increment & ~adjust_decrement; dec = adjust_decrement & ~adjust_increment. Both high or both low means no request.
- The mode is valid only when adjust_mode is exactly one-hot. Zero or multi-hot counts as no request.
- Request = (inc | dec) & valid mode. Its key is {direction, adjust_mode}.
- A trigger occurs when the request goes from false to true, or when the key changes while the request stays true.
- FSM states: IDLE, HOLD, REPEAT.
  - IDLE: on a trigger, emit a pulse, load the counter with HOLD_CYCLES-1, and go to HOLD.
  - HOLD: count down. At 0, emit a pulse, load REPEAT_CYCLES-1, and go to REPEAT.
  - REPEAT: count down. At 0, emit a pulse and reload the current repeat period.
  - In any state, request false: go to IDLE, clear the counter and repeat count, emit no pulse.
  - In HOLD or REPEAT, a trigger (key change): emit an immediate pulse on the new key, reload HOLD_CYCLES-1, go to HOLD, and clear the repeat count.
- Pulse encoding: step_inc = adjust_mode when the direction is inc, otherwise 0. step_dec is the same for dec. At most one bit across both buses is high in any cycle.

## Timing
- Reset values: step_inc = 0, step_dec = 0, busy = 0, state = IDLE, counter = 0, repeat count = 0. Previous-request and previous-key registers are cleared, so a button already held when rst falls triggers on the first edge after reset.
- rst asserted mid-operation: outputs clear immediately, without waiting for a clk edge.
- Outputs are registered. A trigger sampled at edge E drives a pulse during cycle E→E+1.
- First repeat pulse is sampled at edge E+HOLD_CYCLES. Later pulses follow every REPEAT_CYCLES edges.
- A release sampled at edge R leaves no pulse after edge R. A pulse due at R is suppressed.
- Counter reload and the pulse happen at the same edge.

## Configuration
- Macro: ADJUST_ACCEL_EN.
- Defined:
  - A saturating repeat counter (width clog2(ACCEL_AFTER+1)) counts pulses emitted in REPEAT.
  - Once it reaches ACCEL_AFTER, the reload value becomes ACCEL_REPEAT_CYCLES-1.
  - Any trigger or release clears the count.
- Not defined: the repeat counter logic is absent, and the period is always REPEAT_CYCLES. ACCEL_* parameters are ignored.

## Test plan
All scenarios use FIELDS=3, HOLD_CYCLES=4, REPEAT_CYCLES=3, with E = the edge that samples the press.

- **Reset hold and auto-repeat.** rst high, adjust_increment=1, adjust_mode=3'b010 held, then rst released. Required: busy=0 and pulses=0 while rst is high; after rst falls, step_inc=3'b010 at E, E+4, E+7, E+10.
- **Release timing.** Mode 3'b001 with increment held for 6 cycles, then released. Required: pulses only at E and E+4; busy=0 the cycle after release.
- **Mode switch while held.** Mode 3'b010 with increment held; mode changes to 3'b001 at edge E+2. Required: step_inc=3'b001 at E+2, then at E+6; no 3'b010 pulse at E+4.
- **Invalid request combinations.**
  - Both buttons high with mode 3'b100: no pulses, busy=0.
  - Mode 3'b011 with increment high: no pulses.
  - Then mode changes to 3'b100: step_inc=3'b100 at the next edge.
- **Decrement and direction switch.** Decrement held with mode 3'b100. Required: step_dec=3'b100 at E, step_inc stays 0. Switching to increment, sampled at edge X, gives step_inc=3'b100 at X, then at X+4.
- **Acceleration (ADJUST_ACCEL_EN, ACCEL_AFTER=2, ACCEL_REPEAT_CYCLES=2).** Increment held. Required: pulses at E, E+4, E+7, E+10, E+12, E+14. Without the macro the same stimulus gives E, E+4, E+7, E+10, E+13, E+16.
